// File: rtl/rca_4bit_checker.sv
// rca_4bit_checker: captures operands for a 4-bit ripple-carry adder,
// waits SETTLE_CYC cycles, then checks the adder's {cout,sum} result.
// Ports: clk, rst_n (async active-low), in_valid/in_ready handshake,
//   a, b, cin (operands), sum, cout (adder outputs under test), clr,
//   pass_cnt, fail_cnt (saturating), err (sticky), err_vec (first
//   failing {a,b,cin,cout,sum}), exp_out (last expected {cout,sum}).
// Macro RCA_CHK_STOP_ON_ERR_EN: a mismatch parks the FSM in HALT until
//   clr or reset.
module rca_4bit_checker #(
    parameter int SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  a,
    input  logic [3:0]  b,
    input  logic        cin,
    input  logic [3:0]  sum,
    input  logic        cout,
    input  logic        clr,
    output logic [7:0]  pass_cnt,
    output logic [7:0]  fail_cnt,
    output logic        err,
    output logic [13:0] err_vec,
    output logic [4:0]  exp_out
);

`ifdef RCA_CHK_STOP_ON_ERR_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CMP  = 2'd2,
        HALT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CMP  = 2'd2
    } state_t;
`endif

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  a_q, a_d;
    logic [3:0]  b_q, b_d;
    logic        cin_q, cin_d;
    logic [3:0]  sum_q, sum_d;
    logic        cout_q, cout_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  pass_q, pass_d;
    logic [7:0]  fail_q, fail_d;
    logic        err_q, err_d;
    logic [13:0] ev_q, ev_d;
    logic [4:0]  exp_q, exp_d;
    // Holds in_ready low until the first edge after reset release.
    logic        init_q;

    logic [4:0]  exp_w;
    logic        mis_w;

    assign exp_w = {1'b0, a_q} + {1'b0, b_q} + {4'b0, cin_q};
    assign mis_w = (exp_w != {cout_q, sum_q});

    assign in_ready = init_q && (state_q == IDLE);
    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign err      = err_q;
    assign err_vec  = ev_q;
    assign exp_out  = exp_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        err_d   = err_q;
        ev_d    = ev_q;
        exp_d   = exp_q;
        if (clr) begin
            // Clear wins over any accept or compare on the same edge.
            state_d = IDLE;
            pass_d  = 8'd0;
            fail_d  = 8'd0;
            err_d   = 1'b0;
            ev_d    = 14'd0;
            exp_d   = 5'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_d     = a;
                        b_d     = b;
                        cin_d   = cin;
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        sum_d   = sum;
                        cout_d  = cout;
                        state_d = CMP;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                CMP: begin
                    exp_d = exp_w;
                    if (mis_w) begin
                        if (fail_q != 8'hFF) begin
                            fail_d = fail_q + 8'd1;
                        end
                        if (!err_q) begin
                            err_d = 1'b1;
                            ev_d  = {a_q, b_q, cin_q, cout_q, sum_q};
                        end
`ifdef RCA_CHK_STOP_ON_ERR_EN
                        state_d = HALT;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        if (pass_q != 8'hFF) begin
                            pass_d = pass_q + 8'd1;
                        end
                        state_d = IDLE;
                    end
                end
`ifdef RCA_CHK_STOP_ON_ERR_EN
                HALT: begin
                    state_d = HALT;
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            cin_q   <= 1'b0;
            sum_q   <= 4'd0;
            cout_q  <= 1'b0;
            cnt_q   <= 4'd0;
            pass_q  <= 8'd0;
            fail_q  <= 8'd0;
            err_q   <= 1'b0;
            ev_q    <= 14'd0;
            exp_q   <= 5'd0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            ev_q    <= ev_d;
            exp_q   <= exp_d;
            init_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rca_4bit_checker.sv
// tb_rca_4bit_checker: randomized self-checking bench for
// rca_4bit_checker against a plain-arithmetic reference model.
module tb_rca_4bit_checker;

    localparam int SETTLE_CYC = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        cin;
    logic [3:0]  sum;
    logic        cout;
    logic        clr;
    logic [7:0]  pass_cnt;
    logic [7:0]  fail_cnt;
    logic        err;
    logic [13:0] err_vec;
    logic [4:0]  exp_out;

    int tests = 0;
    int fails = 0;

    int          m_pass;
    int          m_fail;
    logic        m_err;
    logic [13:0] m_ev;
    logic [4:0]  m_exp;
    bit          halted;

    rca_4bit_checker #(.SETTLE_CYC(SETTLE_CYC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sum      (sum),
        .cout     (cout),
        .clr      (clr),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt),
        .err      (err),
        .err_vec  (err_vec),
        .exp_out  (exp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_zero();
        m_pass = 0;
        m_fail = 0;
        m_err  = 1'b0;
        m_ev   = 14'd0;
        m_exp  = 5'd0;
    endtask

    task automatic chk_outs(input string tag);
        check({tag, ".pass"}, pass_cnt, m_pass);
        check({tag, ".fail"}, fail_cnt, m_fail);
        check({tag, ".err"},  err,      m_err);
        check({tag, ".ev"},   err_vec,  m_ev);
        check({tag, ".exp"},  exp_out,  m_exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_zero();
        halted = 1'b0;
    endtask

    task automatic run_chk(input logic [3:0] ta, input logic [3:0] tb_,
                           input logic tc, input logic [3:0] ts,
                           input logic tco);
        int n;
        int e;
        bit mis;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("rdy_pre", in_ready, 1);
        a = ta;
        b = tb_;
        cin = tc;
        sum = ts;
        cout = tco;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        e = int'(ta) + int'(tb_) + int'(tc);
        mis = (e != int'({tco, ts}));
        m_exp = 5'(e);
        if (mis) begin
            if (m_fail < 255) m_fail++;
            if (!m_err) m_ev = {ta, tb_, tc, tco, ts};
            m_err = 1'b1;
        end else begin
            if (m_pass < 255) m_pass++;
        end
`ifdef RCA_CHK_STOP_ON_ERR_EN
        if (mis) begin
            repeat (SETTLE_CYC + 1) tick();
            check("halt_rdy", in_ready, 0);
            chk_outs("halt");
            halted = 1'b1;
        end
`endif
        if (!halted) begin
            n = 1;
            while (!in_ready && n < 100) begin
                tick();
                n++;
            end
            check("latency", n, SETTLE_CYC + 2);
            chk_outs("res");
        end
    endtask

    initial begin
        logic [3:0] ra, rb, rs;
        logic       rc, rco;
        logic [4:0] re;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = 4'd0;
        b = 4'd0;
        cin = 1'b0;
        sum = 4'd0;
        cout = 1'b0;
        clr = 1'b0;
        halted = 1'b0;
        model_zero();

        repeat (3) tick();
        check("rst_rdy", in_ready, 0);
        chk_outs("rst");
        #3 rst_n = 1'b1;
        #1 check("rel_rdy", in_ready, 0);
        tick();
        check("rdy_after_edge", in_ready, 1);

        run_chk(4'hF, 4'h0, 1'b0, 4'hF, 1'b0);
        check("m1_pass", pass_cnt, 1);
        check("m1_exp", exp_out, 5'h0F);
        check("m1_err", err, 0);

        run_chk(4'hF, 4'hF, 1'b1, 4'hE, 1'b1);
        check("mm_fail", fail_cnt, 1);
        check("mm_err", err, 1);
        check("mm_exp", exp_out, 5'h1F);
        check("mm_ev", err_vec, 14'h3FFE);
`ifdef RCA_CHK_STOP_ON_ERR_EN
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("hold_rdy", in_ready, 0);
            check("hold_fail", fail_cnt, 1);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        model_zero();
        halted = 1'b0;
        check("unhalt_rdy", in_ready, 1);
        chk_outs("unhalt");
`else
        run_chk(4'h1, 4'h2, 1'b0, 4'h0, 1'b0);
        check("mm2_fail", fail_cnt, 2);
        check("mm2_ev", err_vec, 14'h3FFE);
`endif

        do_clr();
        run_chk(4'h5, 4'h6, 1'b1, 4'hC, 1'b0);
        check("pre_col", pass_cnt, 1);
        a = 4'h3;
        b = 4'h4;
        cin = 1'b0;
        sum = 4'h7;
        cout = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (SETTLE_CYC) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_zero();
        check("col_rdy", in_ready, 1);
        chk_outs("col");

        for (int i = 0; i < 260; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            rc = 1'($urandom);
            re = 5'(int'(ra) + int'(rb) + int'(rc));
            run_chk(ra, rb, rc, re[3:0], re[4]);
        end
        check("sat_pass", pass_cnt, 255);
        check("sat_fail", fail_cnt, 0);

        do_clr();
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            rc = 1'($urandom);
            re = 5'(int'(ra) + int'(rb) + int'(rc));
            if ($urandom_range(0, 3) == 0) begin
                re = re ^ 5'($urandom_range(1, 31));
            end
            rs = re[3:0];
            rco = re[4];
            run_chk(ra, rb, rc, rs, rco);
            if (halted) do_clr();
        end

        run_chk(4'h2, 4'h2, 1'b0, 4'h4, 1'b0);
        check("pre_rst", pass_cnt != 0, 1);
        a = 4'h9;
        b = 4'h1;
        cin = 1'b1;
        sum = 4'hB;
        cout = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_zero();
        check("mid_rdy", in_ready, 0);
        chk_outs("mid_rst");
        tick();
        #3 rst_n = 1'b1;
        #1 check("mid_rel_rdy", in_ready, 0);
        tick();
        check("mid_after_rdy", in_ready, 1);
        repeat (SETTLE_CYC + 2) tick();
        chk_outs("mid_after");
        run_chk(4'h8, 4'h7, 1'b1, 4'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
